// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time, fixed wait states,
// single-cycle response strobe, pipeline stall while an access is outstanding.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                we_q;
    logic                mis_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic [31:0]         mem [0:(1<<ADDR_W)-1];

    logic                accept;
    logic                do_access;
    logic                acc_we;
    logic                acc_mis;
    logic [ADDR_W-1:0]   acc_idx;
    logic [3:0]          acc_be;
    logic [31:0]         acc_wdata;

    // Upper address bits are don't-care: addresses wrap modulo the array size.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign accept = (state == IDLE) && req_valid && req_ready;
    assign stall  = req_valid && !resp_valid;

    // With zero wait states the access happens on the accept edge, so it uses the live request.
    always_comb begin
        acc_we    = we_q;
        acc_mis   = mis_q;
        acc_idx   = idx_q;
        acc_be    = be_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_mis   = (req_addr[1:0] != 2'b00);
            acc_idx   = req_addr[ADDR_W+1:2];
            acc_be    = req_be;
            acc_wdata = req_wdata;
        end
        if (WAIT_CYCLES == 0) do_access = accept;
        else                  do_access = (state == WAIT) && (cnt == 4'd1);
    end

    // Array is not reset; rst_n gating only blocks a write attempted while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && do_access && acc_we && !acc_mis) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            mis_q      <= 1'b0;
            idx_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        mis_q     <= (req_addr[1:0] != 2'b00);
                        idx_q     <= req_addr[ADDR_W+1:2];
                        be_q      <= req_be;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        cnt       <= 4'(WAIT_CYCLES);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (do_access) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= acc_mis;
                resp_rdata <= (acc_mis || acc_we) ? '0 : mem[acc_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked every cycle against
// a transaction-level memory model, plus directed literal expectations.
module tb_dmem_responder;

    localparam int WC [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [3:0]  req_be     [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        stall      [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc1   = 0;

    // Model state: per instance, what the outputs must be in the current cycle.
    logic        m_ready [2];
    logic        m_valid [2];
    logic        m_err   [2];
    logic [31:0] m_rdata [2];
    logic        m_known [2];
    logic        m_busy  [2];
    int          m_resp_cyc [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [3:0]  m_be    [2];
    logic [31:0] m_wd    [2];
    logic [31:0] mm [int];

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .stall(stall[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .stall(stall[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at cycle %0d: bound expired", name, cyc);
    endfunction

    function automatic void model_reset(int d);
        m_ready[d] = 1'b1;
        m_valid[d] = 1'b0;
        m_err[d]   = 1'b0;
        m_rdata[d] = '0;
        m_known[d] = 1'b1;
        m_busy[d]  = 1'b0;
    endfunction

    function automatic void perform(int d);
        int key;
        logic [31:0] w;
        key = d * 65536 + int'((m_addr[d] >> 2) & 32'h3FF);
        m_known[d] = 1'b1;
        if (m_addr[d][1:0] != 2'b00) begin
            m_rdata[d] = '0;
            m_err[d]   = 1'b1;
        end else if (m_we[d]) begin
            m_rdata[d] = '0;
            m_err[d]   = 1'b0;
            if (mm.exists(key) || m_be[d] == 4'hF) begin
                w = mm.exists(key) ? mm[key] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (m_be[d][b]) w[8*b +: 8] = m_wd[d][8*b +: 8];
                mm[key] = w;
            end else begin
                mm.delete(key);
            end
        end else begin
            m_err[d] = 1'b0;
            if (mm.exists(key)) m_rdata[d] = mm[key];
            else                m_known[d] = 1'b0;
        end
    endfunction

    // Advance the model from the current cycle to the next one.
    function automatic void model_step(int d);
        if (m_valid[d]) begin
            m_valid[d] = 1'b0;
            m_ready[d] = 1'b1;
        end else if (m_busy[d]) begin
            if (cyc + 1 == m_resp_cyc[d]) begin
                perform(d);
                m_valid[d] = 1'b1;
                m_busy[d]  = 1'b0;
            end
        end else if (req_valid[d]) begin
            m_we[d]       = req_we[d];
            m_addr[d]     = req_addr[d];
            m_be[d]       = req_be[d];
            m_wd[d]       = req_wdata[d];
            m_ready[d]    = 1'b0;
            m_resp_cyc[d] = cyc + 1 + WC[d];
            if (WC[d] == 0) begin
                perform(d);
                m_valid[d] = 1'b1;
            end else begin
                m_busy[d] = 1'b1;
            end
        end
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) model_reset(d);
            chk($sformatf("req_ready[%0d]", d), 32'(req_ready[d]), 32'(m_ready[d]));
            chk($sformatf("resp_valid[%0d]", d), 32'(resp_valid[d]), 32'(m_valid[d]));
            chk($sformatf("stall[%0d]", d), 32'(stall[d]), 32'(req_valid[d] && !m_valid[d]));
            chk($sformatf("resp_err[%0d]", d), 32'(resp_err[d]), 32'(m_err[d]));
            if (m_known[d]) chk($sformatf("resp_rdata[%0d]", d), resp_rdata[d], m_rdata[d]);
            if (rst_n) model_step(d);
        end
        if (rst_n && req_valid[1] && req_ready[1]) acc1++;
    end

    // Called just after a rising edge; holds the request until its response.
    task automatic xfer(input int d, input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic drop, output logic [31:0] rd,
                        output logic er, output int acc_cyc, output int rsp_cyc);
        int n;
        rd = '0; er = 1'b0; acc_cyc = 0; rsp_cyc = 0;
        req_we[d] = we; req_addr[d] = addr; req_be[d] = be; req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready[d]) break;
            if (++n > 40) begin
                fail_now("accept_timeout");
                req_valid[d] = 1'b0;
                return;
            end
        end
        acc_cyc = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid[d] && n < 40);
        if (!resp_valid[d]) begin
            fail_now("resp_timeout");
            req_valid[d] = 1'b0;
            return;
        end
        rd = resp_rdata[d];
        er = resp_err[d];
        rsp_cyc = cyc;
        @(posedge clk);
        #2;
        if (drop) req_valid[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          a, r, prev_r, acc_base, n;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_be[d] = '0; req_wdata[d] = '0;
            model_reset(d);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_rdata", resp_rdata[0], 32'h0);
        chk("rst_err", 32'(resp_err[0]), 32'd0);
        chk("rst_stall", 32'(stall[0]), 32'd0);
        @(posedge clk); #2;

        xfer(0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 1'b1, rd, er, a, r);
        chk("store_latency", 32'(r - a), 32'd3);
        chk("store_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, rd, er, a, r);
        chk("load_latency", 32'(r - a), 32'd3);
        chk("load_data", rd, 32'hDEADBEEF);

        xfer(0, 1'b1, 32'h80, 4'hF, 32'h11223344, 1'b1, rd, er, a, r);
        xfer(0, 1'b1, 32'h80, 4'b0101, 32'hAABBCCDD, 1'b1, rd, er, a, r);
        xfer(0, 1'b0, 32'h80, 4'h0, 32'h0, 1'b1, rd, er, a, r);
        chk("byte_enable_merge", rd, 32'h11BB33DD);
        xfer(0, 1'b1, 32'h80, 4'h0, 32'hFFFFFFFF, 1'b1, rd, er, a, r);
        xfer(0, 1'b0, 32'h80, 4'h0, 32'h0, 1'b1, rd, er, a, r);
        chk("be_zero_noop", rd, 32'h11BB33DD);

        xfer(0, 1'b1, 32'h42, 4'hF, 32'h55555555, 1'b1, rd, er, a, r);
        chk("misaligned_err", 32'(er), 32'd1);
        chk("misaligned_rdata", rd, 32'h0);
        xfer(0, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, rd, er, a, r);
        chk("misaligned_no_write", rd, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h43, 4'h0, 32'h0, 1'b1, rd, er, a, r);
        chk("misaligned_load_err", 32'(er), 32'd1);

        xfer(0, 1'b0, 32'h0000_1040, 4'h0, 32'h0, 1'b1, rd, er, a, r);
        chk("addr_wrap", rd, 32'hDEADBEEF);
        xfer(0, 1'b1, 32'h8000_0FFC, 4'hF, 32'hCAFEF00D, 1'b1, rd, er, a, r);
        xfer(0, 1'b0, 32'h0000_0FFC, 4'h0, 32'h0, 1'b1, rd, er, a, r);
        chk("top_word", rd, 32'hCAFEF00D);

        req_we[0] = 1'b1; req_addr[0] = 32'h100; req_be[0] = 4'hF; req_wdata[0] = 32'h12345678;
        req_valid[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[0] && n < 40);
        if (!req_ready[0]) fail_now("abort_accept_timeout");
        @(posedge clk); #2;
        rst_n = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(resp_valid[0]), 32'd0);
        chk("abort_ready", 32'(req_ready[0]), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        xfer(0, 1'b1, 32'h100, 4'hF, 32'h0, 1'b1, rd, er, a, r);
        xfer(0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, rd, er, a, r);
        chk("abort_no_write", rd, 32'h0);

        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b1, 32'h200 + 32'(4 * i), 4'hF, 32'hC0DE0000 + 32'(i), 1'b1, rd, er, a, r);
            chk("w0_store_latency", 32'(r - a), 32'd1);
        end
        acc_base = acc1;
        prev_r = 0;
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b0, 32'h200 + 32'(4 * i), 4'h0, 32'h0, (i == 3), rd, er, a, r);
            chk("w0_load_data", rd, 32'hC0DE0000 + 32'(i));
            if (i > 0) chk("w0_spacing", 32'(r - prev_r), 32'd2);
            prev_r = r;
        end
        @(negedge clk);
        chk("w0_accept_count", 32'(acc1 - acc_base), 32'd4);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far side of the MEM-stage memory port. Accepts one load or store request at a time from the EX/MEM pipeline register, applies a fixed programmable wait-state delay, and services the access against an internal word-addressed array. While an access is in flight it holds the pipeline with `stall`. It returns load data as a single-cycle response that the MEM stage forwards to writeback as its memory output.

## Interface
- `ADDR_W`, default 10: word-index width; array depth is 2**ADDR_W words.
- `WAIT_CYCLES`, default 2: wait states inserted between acceptance and response, 0..15.
- `clk`  in  1  clock; all state updates occur on its rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `req_valid`  in  1  request present; held by the pipeline until the response.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_be`  in  4  store byte enables; bit i enables byte i (bits [8i+7:8i]); ignored for loads.
- `req_wdata`  in  32  store data.
- `req_ready`  out  1  request is accepted at this edge when `req_valid && req_ready`.
- `stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- `resp_valid`  out  1  single-cycle response strobe.
- `resp_rdata`  out  32  load data, valid with `resp_valid`.
- `resp_err`  out  1  misaligned access flag, valid with `resp_valid`.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - `req_ready`=1.
  - On accept, latch `req_we`, word index `req_addr[ADDR_W+1:2]`, `req_be` and `req_wdata`. Set misaligned = `(req_addr[1:0] != 0)`.
  - If `WAIT_CYCLES`=0, go directly to RESP. Otherwise load the 4-bit counter with `WAIT_CYCLES` and go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When the counter equals 1, perform the access and go to RESP at that edge.
- The access is performed on the edge entering RESP:
  - Store, aligned: write only the enabled bytes. `be`=0000 is a legal no-op.
  - Load, aligned: register the array word into `resp_rdata`.
  - Misaligned: no array write; `resp_rdata`=0 and `resp_err`=1.
  - Aligned store: `resp_rdata`=0 and `resp_err`=0.
- RESP:
  - `resp_valid`=1 for exactly one cycle, then unconditionally go to IDLE.
  - `req_ready`=0, so the still-asserted request is not re-accepted.
- Address bits above `ADDR_W+1` are ignored, so addresses wrap modulo the array size.
- `stall` = `req_valid && !resp_valid`. The pipeline advances at the end of the RESP cycle.
- `resp_rdata` and `resp_err` hold their value outside RESP until the next response.
- Array contents are not reset.

## Timing
- Reset values: state=IDLE, counter=0, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- `stall` follows `req_valid` during reset.
- A request presented in cycle N is accepted at the end of N. WAIT occupies cycles N+1..N+WAIT_CYCLES, and RESP is cycle N+WAIT_CYCLES+1.
- Occupancy is WAIT_CYCLES+2 cycles per access. The earliest next accept is cycle N+WAIT_CYCLES+2.
- With `WAIT_CYCLES`=0: RESP at N+1, and back-to-back accesses occur every 2 cycles.
- `req_*` changes after acceptance do not affect the in-flight access.
- Reset asserted in WAIT aborts the access with no array write, no response, and all outputs at their reset values immediately.
- Reset asserted in RESP clears `resp_valid` immediately. A store already committed stays committed.

## Test plan
- Reset check: apply reset with `req_valid`=0, then release → `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `stall`=0.
- Store then load, W=2:
  - Store 0xDEADBEEF, be=1111 to 0x40, accepted in cycle 0 → `stall`=1 in cycles 0–2, `resp_valid`=1 in cycle 3.
  - Load 0x40 accepted in cycle 4 → `resp_valid`=1 in cycle 7 with `resp_rdata`=0xDEADBEEF.
- Byte enables: store 0x11223344, be=1111 to 0x80, then store 0xAABBCCDD, be=0101 → a load of 0x80 returns 0x11BB33DD.
- Misaligned store to 0x42 → `resp_err`=1 and `resp_rdata`=0 in RESP; a later load of 0x40 returns its prior contents unchanged.
- Back-to-back with W=0: `req_valid` held high across four loads → `resp_valid` in every second cycle, and each request is accepted exactly once.
- Reset mid-operation: assert `rst_n`=0 during WAIT of a store of 0x12345678 to 0x100 → no `resp_valid`. After reset release, store a known value 0 to 0x100 first; a following load returns 0, not 0x12345678.
